poca_axil_reg_slave: RTL and testbench
======================================

// Module: poca_axil_reg_slave
// PURPOSE
//  AXI4-Lite slave register bank; the downstream endpoint of the POCA AXI master.
//  Accepts single-beat writes/reads, applies WSTRB byte enables, returns OKAY/SLVERR.
//  Exposes all registers plus a one-cycle write-event strobe to the security-engine core.
//  Register 0 is a read-only ID; all other registers are read/write.
// PARAMETERS
//  ADDR_W    32            AXI address width
//  DATA_W    32            AXI data width (fixed 32; WSTRB is 4 bits)
//  NUM_REGS  16            register count, 2..256; word index = addr[ADDR_W-1:2]
//  ID_VALUE  32'hC0CA_0001 constant returned by register 0
// PORTS
//  S_AXI_ACLK     in   1                 clock
//  S_AXI_ARESETN  in   1                 async active-low reset
//  S_AXI_AWADDR   in   ADDR_W            write address
//  S_AXI_AWPROT   in   3                 ignored
//  S_AXI_AWVALID  in   1                 write address valid
//  S_AXI_AWREADY  out  1                 write address ready
//  S_AXI_WDATA    in   32                write data
//  S_AXI_WSTRB    in   4                 byte enables
//  S_AXI_WVALID   in   1                 write data valid
//  S_AXI_WREADY   out  1                 write data ready
//  S_AXI_BRESP    out  2                 00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1                 write response valid
//  S_AXI_BREADY   in   1                 write response ready
//  S_AXI_ARADDR   in   ADDR_W            read address
//  S_AXI_ARPROT   in   3                 ignored
//  S_AXI_ARVALID  in   1                 read address valid
//  S_AXI_ARREADY  out  1                 read address ready
//  S_AXI_RDATA    out  32                read data
//  S_AXI_RRESP    out  2                 00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1                 read data valid
//  S_AXI_RREADY   in   1                 read data ready
//  regs_o         out  NUM_REGS*32       flattened registers, reg i at [32i+31:32i]
//  wr_pulse_o     out  1                 1-cycle strobe on each committed in-range write
//  wr_index_o     out  8                 index of that write, valid with wr_pulse_o
// BEHAVIOUR
//  Reset (async, ARESETN=0): all regs 0 (reg0 reads ID_VALUE); all READY/VALID=0;
//   BRESP=RRESP=00; RDATA=0; wr_pulse_o=0; aw_held=w_held=0. A registered rdy_en flag is
//   set on the first clock edge after release; all READYs are gated by it.
//  Write path: AW and W are captured independently, in either order or the same cycle.
//   AWREADY = rdy_en & ~aw_held & ~BVALID; WREADY = rdy_en & ~w_held & ~BVALID.
//   Handshake sets the held flag and latches AWADDR or WDATA/WSTRB.
//   Commit occurs on the edge after both flags are set (clear flags, set BVALID):
//   in range -> apply WSTRB per byte, BRESP=00, wr_pulse_o=1 for 1 cycle.
//   BVALID holds until BREADY; no new AW/W is accepted while BVALID=1.
//   Min latency: AW+W same cycle at edge N -> commit/BVALID at edge N+1.
//  Write to reg0: OKAY, no state change, no wr_pulse_o.
//  Read path: ARREADY = rdy_en & ~RVALID. On AR handshake, RDATA/RRESP are registered and
//   RVALID=1 on the same edge (latency 1). RDATA/RRESP hold stable until RREADY.
//  Decode: index = addr[ADDR_W-1:2]; addr[1:0] ignored. Out of range (index >= NUM_REGS):
//   write dropped, BRESP=10, no pulse; read RDATA=0, RRESP=10.
//  Read and write channels are fully concurrent. A commit and a read of the same register
//   on the same edge: the read returns the pre-write value.
//  Reset mid-transaction: in-flight AW/W/B/R state is discarded; no response is issued.
// STRUCTURE
//  Shared package poca_axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ID_VALUE default,
//   and register index constants.
//  One sub-module, poca_axil_wr_capture: AW/W held-flag capture and commit logic.
//   Read path and register array stay in the top module.
// TESTING
//  T1 reset: ARESETN low 2 cycles -> all VALID/READY=0; READYs=1 one edge after release.
//  T2 AW+W same cycle, addr 0x4, data 0xDEADBEEF, strb F -> BVALID next edge, BRESP=00,
//     wr_pulse_o=1, wr_index_o=1; read 0x4 returns 0xDEADBEEF.
//  T3 W 3 cycles before AW, addr 0x8, data 0x11223344, strb 0101 over 0xFFFFFFFF
//     -> reg2=0xFF22FF44; WREADY=0 until commit.
//  T4 BREADY held low 5 cycles -> BVALID held; AWREADY=WREADY=0 throughout; next write
//     is accepted only after the B handshake.
//  T5 write/read 0x40 with NUM_REGS=16 -> BRESP=10, RRESP=10, RDATA=0, no reg change.
//  T6 read reg0 -> 0xC0CA0001; write reg0 -> OKAY, value unchanged; read reg1 during its
//     commit edge -> old value.

Source files
------------

// File: rtl/poca_axil_pkg.sv
// rtl/poca_axil_pkg.sv - shared constants and helpers for the POCA AXI4-Lite register slave
package poca_axil_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_SLVERR      = 2'b10;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hC0CA_0001;

  // Register 0 is the read-only ID word; everything from 1 upwards is read/write.
  localparam int REG_ID_IDX       = 0;
  localparam int REG_FIRST_RW_IDX = 1;

  // Merge new write data into an old word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/poca_axil_reg_slave_if.sv
// rtl/poca_axil_reg_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface poca_axil_reg_slave_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/poca_axil_wr_capture.sv
// rtl/poca_axil_wr_capture.sv - independent AW/W capture, write commit and B response
module poca_axil_wr_capture
  import poca_axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy_en,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit_en,
  output logic [ADDR_W-3:0] commit_idx,
  output logic [31:0]       commit_data,
  output logic [3:0]        commit_strb,
  output logic              wr_pulse,
  output logic [7:0]        wr_index
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX       = IDX_W'(REG_ID_IDX);

  logic             aw_held;
  logic             w_held;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic [3:0]       strb_q;
  logic             commit;
  logic             in_range;
  logic             writable;
  logic             unused_ok;

  // Byte offset within a word carries no meaning for this bank.
  assign unused_ok = ^awaddr[1:0];

  assign awready  = rdy_en & ~aw_held & ~bvalid;
  assign wready   = rdy_en & ~w_held & ~bvalid;
  assign commit   = aw_held & w_held;
  assign in_range = idx_q < NUM_REGS_IDX;
  assign writable = in_range && (idx_q != ID_IDX);

  assign commit_en   = commit & writable;
  assign commit_idx  = idx_q;
  assign commit_data = data_q;
  assign commit_strb = strb_q;

  // Hold AW and W halves until both are present, then commit and raise the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        idx_q   <= awaddr[ADDR_W-1:2];
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid   <= 1'b1;
        bresp    <= in_range ? RESP_OKAY : RESP_SLVERR;
        wr_pulse <= writable;
        wr_index <= idx_q[7:0];
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/poca_axil_reg_slave.sv
// rtl/poca_axil_reg_slave.sv - AXI4-Lite register bank with read-only ID word and write strobe
module poca_axil_reg_slave
  import poca_axil_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  poca_axil_reg_slave_if.slave     axi,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic                     wr_pulse_o,
  output logic [7:0]               wr_index_o
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

  logic              rdy_en;
  logic              commit_en;
  logic [IDX_W-1:0]  commit_idx;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic [DATA_W-1:0] regs_rw   [REG_FIRST_RW_IDX:NUM_REGS-1];
  logic [DATA_W-1:0] regs_view [NUM_REGS];
  logic [IDX_W-1:0]  ar_idx;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;
  logic              unused_ok;

  // Protection bits and byte offsets are accepted but carry no meaning here.
  assign unused_ok = ^{axi.awprot, axi.arprot, axi.araddr[1:0]};

  // READYs stay low until one full clock after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rdy_en <= 1'b0;
    else                rdy_en <= 1'b1;
  end

  poca_axil_wr_capture #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_capture (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .rdy_en      (rdy_en),
    .awaddr      (axi.awaddr),
    .awvalid     (axi.awvalid),
    .awready     (axi.awready),
    .wdata       (axi.wdata),
    .wstrb       (axi.wstrb),
    .wvalid      (axi.wvalid),
    .wready      (axi.wready),
    .bresp       (axi.bresp),
    .bvalid      (axi.bvalid),
    .bready      (axi.bready),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb),
    .wr_pulse    (wr_pulse_o),
    .wr_index    (wr_index_o)
  );

  // Read/write registers; the ID word is never stored, only reported.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = REG_FIRST_RW_IDX; i < NUM_REGS; i++) regs_rw[i] <= '0;
    end else if (commit_en) begin
      for (int i = REG_FIRST_RW_IDX; i < NUM_REGS; i++) begin
        if (commit_idx == IDX_W'(i)) regs_rw[i] <= apply_wstrb(regs_rw[i], commit_data, commit_strb);
      end
    end
  end

  // Full register view (ID in slot 0) feeding both the read mux and the flat export.
  always_comb begin
    regs_view[REG_ID_IDX] = ID_VALUE;
    for (int i = REG_FIRST_RW_IDX; i < NUM_REGS; i++) regs_view[i] = regs_rw[i];
  end

  // Flatten the register view onto the core-facing bus.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs_view[i];
  end

  assign ar_idx      = axi.araddr[ADDR_W-1:2];
  assign rd_in_range = ar_idx < NUM_REGS_IDX;

  // Read mux; sees pre-commit register values so a same-edge read returns old data.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_word = regs_view[i];
    end
  end

  assign axi.arready = rdy_en & ~axi.rvalid;

  // Registered read response, held until the master takes it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= RESP_OKAY;
    end else if (axi.arvalid && axi.arready) begin
      axi.rvalid <= 1'b1;
      axi.rdata  <= rd_in_range ? rd_word : '0;
      axi.rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (axi.rvalid && axi.rready) begin
      axi.rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poca_axil_reg_slave.sv
// tb/tb_poca_axil_reg_slave.sv - self-checking bench for the AXI4-Lite register slave
module tb_poca_axil_reg_slave;
  import poca_axil_pkg::*;

  localparam int NREG = 16;
  localparam logic [31:0] ID = 32'hC0CA_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREG*32-1:0] regs;
  logic wr_pulse;
  logic [7:0] wr_index;

  always #5 clk = ~clk;

  poca_axil_reg_slave_if #(.ADDR_W(32)) axi ();

  poca_axil_reg_slave #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(NREG), .ID_VALUE(ID)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .axi           (axi.slave),
    .regs_o        (regs),
    .wr_pulse_o    (wr_pulse),
    .wr_index_o    (wr_index)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    $display("FAIL %s: no handshake within bound, required one", name);
  endtask

  typedef struct { logic [1:0] resp; logic pulse; logic [7:0] idx; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  b_exp_t be;
  r_exp_t re;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          exp_pulse;
  } vec_t;
  vec_t vecs[14];

  // Scoreboard monitor: each new B or R response pops one expectation.
  bit mon_on = 0;
  bit bv_d, bhs_d, rv_d, rhs_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      bv_d = 0; bhs_d = 0; rv_d = 0; rhs_d = 0;
    end else if (mon_on) begin
      if (axi.bvalid && (!bv_d || bhs_d)) begin
        if (b_q.size() == 0) fail_timeout("b_unexpected");
        else begin
          be = b_q.pop_front();
          check("bresp", 32'(axi.bresp), 32'(be.resp));
          check("wr_pulse", 32'(wr_pulse), 32'(be.pulse));
          if (be.pulse) check("wr_index", 32'(wr_index), 32'(be.idx));
        end
      end else begin
        check("no_pulse", 32'(wr_pulse), 32'd0);
      end
      if (axi.rvalid && (!rv_d || rhs_d)) begin
        if (r_q.size() == 0) fail_timeout("r_unexpected");
        else begin
          re = r_q.pop_front();
          check("rdata", axi.rdata, re.data);
          check("rresp", 32'(axi.rresp), 32'(re.resp));
        end
      end
      bv_d = axi.bvalid; bhs_d = axi.bvalid && axi.bready;
      rv_d = axi.rvalid; rhs_d = axi.rvalid && axi.rready;
    end
  end

  task automatic send_aw(input logic [31:0] a);
    bit hs = 0;
    axi.awaddr = a; axi.awvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = axi.awready; end
    if (!hs) fail_timeout("aw_handshake");
    @(posedge clk); #1; axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 0;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = axi.wready; end
    if (!hs) fail_timeout("w_handshake");
    @(posedge clk); #1; axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit hs = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin @(negedge clk); hs = axi.arready; end
    if (!hs) fail_timeout("ar_handshake");
    @(posedge clk); #1; axi.arvalid = 1'b0;
  endtask

  task automatic finish_b();
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin @(negedge clk); seen = axi.bvalid; end
    if (!seen) fail_timeout("bvalid_wait");
    @(posedge clk); #1; axi.bready = 1'b1;
    @(posedge clk); #1; axi.bready = 1'b0;
  endtask

  task automatic finish_r();
    bit seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin @(negedge clk); seen = axi.rvalid; end
    if (!seen) fail_timeout("rvalid_wait");
    @(posedge clk); #1; axi.rready = 1'b1;
    @(posedge clk); #1; axi.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int gap, input logic [1:0] resp, input bit pulse);
    b_q.push_back('{resp: resp, pulse: pulse, idx: a[9:2]});
    fork
      send_w(d, s);
      begin
        for (int i = 0; i < gap; i++) begin
          @(posedge clk); #1;
          check("wready_low_while_held", 32'(axi.wready), 32'd0);
        end
        send_aw(a);
      end
    join
    finish_b();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    r_q.push_back('{data: d, resp: resp});
    send_ar(a);
    finish_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    // is_wr addr data strb gap exp_data exp_resp exp_pulse
    vecs[0]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 32'h0,        RESP_OKAY,   1};
    vecs[1]  = '{0, 32'h04, 32'h0,        4'h0, 0, 32'hDEADBEEF, RESP_OKAY,   0};
    vecs[2]  = '{1, 32'h08, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   1};
    vecs[3]  = '{1, 32'h08, 32'h11223344, 4'h5, 3, 32'h0,        RESP_OKAY,   1};
    vecs[4]  = '{0, 32'h08, 32'h0,        4'h0, 0, 32'hFF22FF44, RESP_OKAY,   0};
    vecs[5]  = '{1, 32'h40, 32'h12345678, 4'hF, 0, 32'h0,        RESP_SLVERR, 0};
    vecs[6]  = '{0, 32'h40, 32'h0,        4'h0, 0, 32'h0,        RESP_SLVERR, 0};
    vecs[7]  = '{0, 32'h00, 32'h0,        4'h0, 0, ID,           RESP_OKAY,   0};
    vecs[8]  = '{1, 32'h00, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        RESP_OKAY,   0};
    vecs[9]  = '{0, 32'h00, 32'h0,        4'h0, 0, ID,           RESP_OKAY,   0};
    vecs[10] = '{1, 32'h3C, 32'hA5A5A5A5, 4'hA, 1, 32'h0,        RESP_OKAY,   1};
    vecs[11] = '{0, 32'h3F, 32'h0,        4'h0, 0, 32'hA500A500, RESP_OKAY,   0};
    vecs[12] = '{0, 32'h44, 32'h0,        4'h0, 0, 32'h0,        RESP_SLVERR, 0};
    vecs[13] = '{0, 32'h0C, 32'h0,        4'h0, 0, 32'h0,        RESP_OKAY,   0};

    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;

    // Reset behaviour and the one-edge READY delay after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(axi.awready), 0);
    check("rst_wready", 32'(axi.wready), 0);
    check("rst_arready", 32'(axi.arready), 0);
    check("rst_bvalid", 32'(axi.bvalid), 0);
    check("rst_rvalid", 32'(axi.rvalid), 0);
    check("rst_bresp", 32'(axi.bresp), 0);
    check("rst_rresp", 32'(axi.rresp), 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_wr_pulse", 32'(wr_pulse), 0);
    check("rst_reg0", regs[31:0], ID);
    check("rst_reg1", regs[63:32], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", {29'd0, axi.awready, axi.wready, axi.arready}, 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);
    mon_on = 1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].gap,
                 vecs[i].exp_resp, vecs[i].exp_pulse);
      else
        do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    check("regs_o_reg0", regs[31:0], ID);
    check("regs_o_reg1", regs[63:32], 32'hDEADBEEF);
    check("regs_o_reg2", regs[95:64], 32'hFF22FF44);
    check("regs_o_reg3", regs[127:96], 32'h0);
    check("regs_o_reg15", regs[511:480], 32'hA500A500);

    // BVALID held by BREADY low; a pending write must wait for the B handshake.
    begin
      bit seen = 0;
      b_q.push_back('{resp: RESP_OKAY, pulse: 1'b1, idx: 8'd3});
      b_q.push_back('{resp: RESP_OKAY, pulse: 1'b1, idx: 8'd4});
      fork
        send_aw(32'h0C);
        send_w(32'h0BADF00D, 4'hF);
      join
      for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = axi.bvalid; end
      if (!seen) fail_timeout("t4_bvalid");
      @(posedge clk); #1;
      axi.awaddr = 32'h10; axi.awvalid = 1'b1;
      axi.wdata = 32'h600DCAFE; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        check("t4_bvalid_held", 32'(axi.bvalid), 1);
        check("t4_no_accept", {30'd0, axi.awready, axi.wready}, 0);
      end
      @(posedge clk); #1; axi.bready = 1'b1;
      @(posedge clk); #1; axi.bready = 1'b0;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = axi.awready && axi.wready; end
      if (!seen) fail_timeout("t4_second_accept");
      @(posedge clk); #1; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      finish_b();
      do_read(32'h10, 32'h600DCAFE, RESP_OKAY);
      do_read(32'h0C, 32'h0BADF00D, RESP_OKAY);
    end

    // Read of reg1 on the very edge its new value commits returns the old value.
    r_q.push_back('{data: 32'hDEADBEEF, resp: RESP_OKAY});
    b_q.push_back('{resp: RESP_OKAY, pulse: 1'b1, idx: 8'd1});
    axi.awaddr = 32'h04; axi.awvalid = 1'b1;
    axi.wdata = 32'h01020304; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    check("t6_aw_w_ready", {30'd0, axi.awready, axi.wready}, 32'h3);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.araddr = 32'h04; axi.arvalid = 1'b1;
    @(negedge clk);
    check("t6_arready", 32'(axi.arready), 1);
    check("t6_reg1_before_commit", regs[63:32], 32'hDEADBEEF);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    check("t6_reg1_after_commit", regs[63:32], 32'h01020304);
    check("t6_both_valid", {30'd0, axi.bvalid, axi.rvalid}, 32'h3);
    fork
      finish_b();
      finish_r();
    join
    do_read(32'h04, 32'h01020304, RESP_OKAY);

    repeat (3) @(posedge clk);
    #1;
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
